// File: rtl/usart_pkg.sv
// Shared definitions for the USART receive/transmit blocks.
//   rx_state_e    : receiver frame FSM states
//   OVS           : oversample ticks per bit
//   SAMPLE_PT     : tick within a bit at which the line is sampled
//   BITS_PER_BYTE : data bits per character
//   parity8()     : parity bit a transmitter would send for a byte
package usart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  localparam int OVS           = 16;
  localparam int SAMPLE_PT     = 8;
  localparam int BITS_PER_BYTE = 8;

  // Even parity is the XOR of the data; odd parity inverts it.
  function automatic logic parity8(input logic [7:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/usart_baud_tick.sv
// Oversample tick generator.
//   CLK     : system clock
//   CLR     : synchronous active-high reset
//   restart : realign the divider (start-bit edge); no tick in this cycle
//   tick    : one-CLK pulse every OVS_DIV cycles
module usart_baud_tick #(
  parameter int OVS_DIV = 27
) (
  input  logic CLK,
  input  logic CLR,
  input  logic restart,
  output logic tick
);

  localparam int DW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

  logic [DW-1:0] div_q;
  logic          wrap;

  assign wrap = (div_q == DW'(OVS_DIV - 1));
  assign tick = wrap && !restart;

  always_ff @(posedge CLK) begin
    if (CLR)                  div_q <= '0;
    else if (restart || wrap) div_q <= '0;
    else                      div_q <= div_q + 1'b1;
  end

endmodule

// File: rtl/usart_word_rx.sv
// Multi-byte USART receiver: assembles DATA_BYTES characters (8N1 / 8E1 / 8O1)
// into one word, first byte in the low lane.
//   CLK         : system clock
//   CLR         : synchronous active-high reset
//   Rx          : serial line, idle high, asynchronous
//   CLR_Rec     : read acknowledge; clears Data_Ready, parity_err, overrun
//   Data_Rx     : last completed word (held after acknowledge)
//   Data_Ready  : word valid until acknowledged
//   parity_err  : some byte of the presented word failed parity
//   frame_err   : one-CLK pulse, stop bit sampled low
//   overrun     : sticky, a word completed while Data_Ready was set
//   timeout_err : one-CLK pulse, partial word dropped after inter-byte idle
module usart_word_rx
  import usart_pkg::*;
#(
  parameter int DATA_BYTES   = 4,
  parameter int OVS_DIV      = 27,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic                    Rx,
  input  logic                    CLR_Rec,
  output logic [8*DATA_BYTES-1:0] Data_Rx,
  output logic                    Data_Ready,
  output logic                    parity_err,
  output logic                    frame_err,
  output logic                    overrun,
  output logic                    timeout_err
);

  localparam int W        = 8 * DATA_BYTES;
  localparam int IW       = $clog2(DATA_BYTES + 1);
  localparam int TO_TICKS = TIMEOUT_BITS * OVS;
  localparam int TW       = $clog2(TO_TICKS + 1);

  // Synchroniser; reset high so leaving reset never looks like a start edge.
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= Rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  rx_state_e              state_q;
  logic [3:0]             ovs_q;
  logic [2:0]             bit_q;
  logic [7:0]             shift_q;
  logic [IW-1:0]          idx_q;
  logic [W-1:0]           word_q;
  logic                   wpar_q;
  logic [TW-1:0]          to_q;
  logic [W-1:0]           data_q;
  logic                   rdy_q, perr_q, ferr_q, ovr_q, terr_q;

  logic tick, fall, start_edge, bit_mid, partial, complete;

  assign fall       = rx_prev_q & ~rx_s2_q;
  assign start_edge = (state_q == IDLE) && fall;
  // Past the start bit the 4-bit counter wraps every 16 ticks, so each
  // wrap lands exactly one bit-time after the previous mid-bit sample.
  assign bit_mid    = tick && (ovs_q == 4'(OVS - 1));
  assign partial    = (idx_q != '0) && (idx_q != IW'(DATA_BYTES));
  assign complete   = (idx_q == IW'(DATA_BYTES));

  usart_baud_tick #(.OVS_DIV(OVS_DIV)) u_tick (
    .CLK     (CLK),
    .CLR     (CLR),
    .restart (start_edge),
    .tick    (tick)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      ovs_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      wpar_q  <= 1'b0;
      to_q    <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      terr_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            ovs_q   <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (ovs_q == 4'(SAMPLE_PT - 1)) begin
              ovs_q   <= '0;
              bit_q   <= '0;
              // High at mid start bit is a glitch: drop it silently.
              state_q <= rx_s2_q ? IDLE : DATA;
            end else begin
              ovs_q <= ovs_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) ovs_q <= ovs_q + 4'd1;
          if (bit_mid) begin
            shift_q <= {rx_s2_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'(BITS_PER_BYTE - 1))
              state_q <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (tick) ovs_q <= ovs_q + 4'd1;
          if (bit_mid) begin
            if (rx_s2_q != parity8(shift_q, PARITY_ODD != 0)) wpar_q <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (tick) ovs_q <= ovs_q + 4'd1;
          if (bit_mid) begin
            // Back to IDLE at mid stop bit so a following start edge is seen.
            state_q <= IDLE;
            if (!rx_s2_q) begin
              ferr_q <= 1'b1;
              idx_q  <= '0;
              wpar_q <= 1'b0;
            end else begin
              for (int i = 0; i < DATA_BYTES; i++)
                if (idx_q == IW'(i)) word_q[i*8 +: 8] <= shift_q;
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // Inter-byte watchdog, only between bytes of an unfinished word.
      if (state_q == IDLE && partial && !fall) begin
        if (tick) begin
          if (to_q == TW'(TO_TICKS - 1)) begin
            terr_q <= 1'b1;
            idx_q  <= '0;
            wpar_q <= 1'b0;
            to_q   <= '0;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
      end else begin
        to_q <= '0;
      end

      // Completion takes priority over a same-cycle acknowledge.
      if (complete) begin
        data_q <= word_q;
        perr_q <= wpar_q;
        wpar_q <= 1'b0;
        idx_q  <= '0;
        rdy_q  <= 1'b1;
        ovr_q  <= (ovr_q | rdy_q) & ~CLR_Rec;
      end else if (CLR_Rec) begin
        rdy_q  <= 1'b0;
        perr_q <= 1'b0;
        ovr_q  <= 1'b0;
      end
    end
  end

  assign Data_Rx     = data_q;
  assign Data_Ready  = rdy_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun     = ovr_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_usart_word_rx.sv
module tb_usart_word_rx;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;

  logic        CLK, CLR, CLR_Rec, rx0, rx1;
  logic [31:0] d0;
  logic [15:0] d1;
  logic        rdy0, perr0, ferr0, ovr0, terr0;
  logic        rdy1, perr1, ferr1, ovr1, terr1;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int to_cnt = 0;

  usart_word_rx #(.DATA_BYTES(4), .OVS_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(0),
                  .TIMEOUT_BITS(20)) dut (
    .CLK(CLK), .CLR(CLR), .Rx(rx0), .CLR_Rec(CLR_Rec), .Data_Rx(d0),
    .Data_Ready(rdy0), .parity_err(perr0), .frame_err(ferr0), .overrun(ovr0),
    .timeout_err(terr0));

  usart_word_rx #(.DATA_BYTES(2), .OVS_DIV(DIV), .PARITY_EN(0), .PARITY_ODD(0),
                  .TIMEOUT_BITS(20)) dut2 (
    .CLK(CLK), .CLR(CLR), .Rx(rx1), .CLR_Rec(CLR_Rec), .Data_Rx(d1),
    .Data_Ready(rdy1), .parity_err(perr1), .frame_err(ferr1), .overrun(ovr1),
    .timeout_err(terr1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulse counters for the one-CLK error outputs of the main instance.
  always @(posedge CLK) begin
    if (ferr0) fe_cnt <= fe_cnt + 1;
    if (terr0) to_cnt <= to_cnt + 1;
  end

  task automatic drive(input int line, input logic v, input int n);
    if (line == 0) rx0 = v; else rx1 = v;
    repeat (n) @(negedge CLK);
  endtask

  // Start, 8 data bits LSB first, optional parity (flip=1 corrupts it), stop.
  task automatic send_byte(input int line, input logic [7:0] b, input bit par_en,
                           input bit flip, input logic stop_v);
    drive(line, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(line, b[i], BIT);
    if (par_en) drive(line, (^b) ^ flip, BIT);
    drive(line, stop_v, BIT);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [3:0] flips);
    for (int i = 0; i < 4; i++) send_byte(0, w[i*8 +: 8], 1, flips[i], 1'b1);
  endtask

  task automatic ack();
    @(negedge CLK) CLR_Rec = 1'b1;
    @(negedge CLK) CLR_Rec = 1'b0;
  endtask

  task automatic test_reset();
    CLR = 1'b1; CLR_Rec = 1'b0; rx0 = 1'b1; rx1 = 1'b1;
    repeat (3) @(negedge CLK);
    tests++; if (d0 !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", d0); end
    tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", rdy0); end
    tests++; if ({perr0, ferr0, ovr0, terr0} !== 4'b0)
      begin fails++; $display("FAIL reset_flags: got %b want 0000", {perr0, ferr0, ovr0, terr0}); end
    tests++; if ({rdy1, d1} !== 17'h0) begin fails++; $display("FAIL reset_dut2: got %h want 0", {rdy1, d1}); end
    CLR = 1'b0;
    drive(0, 1'b1, 2 * BIT);
  endtask

  task automatic test_word_ok();
    int fe0 = fe_cnt;
    send_word(32'hDEADBEEF, 4'b0000);
    tests++; if (rdy0 !== 1'b1) begin fails++; $display("FAIL ok_ready: got %b want 1", rdy0); end
    tests++; if (d0 !== 32'hDEADBEEF) begin fails++; $display("FAIL ok_data: got %h want deadbeef", d0); end
    tests++; if (perr0 !== 1'b0) begin fails++; $display("FAIL ok_perr: got %b want 0", perr0); end
    tests++; if (fe_cnt != fe0) begin fails++; $display("FAIL ok_frame: got %0d pulses want 0", fe_cnt - fe0); end
    ack();
    tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL ack_ready: got %b want 0", rdy0); end
    tests++; if (d0 !== 32'hDEADBEEF) begin fails++; $display("FAIL ack_data_held: got %h want deadbeef", d0); end
  endtask

  task automatic test_parity();
    int fe0 = fe_cnt;
    send_word(32'hDEADBEEF, 4'b0100);
    tests++; if (d0 !== 32'hDEADBEEF) begin fails++; $display("FAIL par_data: got %h want deadbeef", d0); end
    tests++; if (perr0 !== 1'b1) begin fails++; $display("FAIL par_perr: got %b want 1", perr0); end
    tests++; if (fe_cnt != fe0) begin fails++; $display("FAIL par_frame: got %0d pulses want 0", fe_cnt - fe0); end
    ack();
    tests++; if (perr0 !== 1'b0) begin fails++; $display("FAIL par_ack: got %b want 0", perr0); end
  endtask

  task automatic test_frame();
    int fe0 = fe_cnt;
    send_byte(0, 8'h55, 1, 0, 1'b1);
    send_byte(0, 8'h66, 1, 0, 1'b0);
    drive(0, 1'b1, 2 * BIT);
    tests++; if (fe_cnt - fe0 != 1) begin fails++; $display("FAIL frame_pulse: got %0d want 1", fe_cnt - fe0); end
    tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL frame_ready: got %b want 0", rdy0); end
    send_word(32'h44332211, 4'b0000);
    tests++; if (d0 !== 32'h44332211) begin fails++; $display("FAIL frame_next: got %h want 44332211", d0); end
    tests++; if (rdy0 !== 1'b1) begin fails++; $display("FAIL frame_next_rdy: got %b want 1", rdy0); end
    ack();
  endtask

  task automatic test_timeout();
    int t0 = to_cnt;
    send_byte(0, 8'h77, 1, 0, 1'b1);
    send_byte(0, 8'h88, 1, 0, 1'b1);
    drive(0, 1'b1, 25 * BIT);
    tests++; if (to_cnt - t0 != 1) begin fails++; $display("FAIL timeout_pulse: got %0d want 1", to_cnt - t0); end
    tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL timeout_ready: got %b want 0", rdy0); end
    send_word(32'hD4C3B2A1, 4'b0000);
    tests++; if (d0 !== 32'hD4C3B2A1) begin fails++; $display("FAIL timeout_next: got %h want d4c3b2a1", d0); end
    ack();
  endtask

  task automatic test_overrun();
    send_word(32'h04030201, 4'b0000);
    tests++; if (ovr0 !== 1'b0) begin fails++; $display("FAIL ovr_first: got %b want 0", ovr0); end
    send_word(32'h08070605, 4'b0000);
    tests++; if (ovr0 !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b want 1", ovr0); end
    tests++; if (d0 !== 32'h08070605) begin fails++; $display("FAIL ovr_data: got %h want 08070605", d0); end
    ack();
    tests++; if ({rdy0, ovr0} !== 2'b00) begin fails++; $display("FAIL ovr_ack: got %b want 00", {rdy0, ovr0}); end
  endtask

  // Random words, random parity faults, gaps and acknowledges against a
  // word-level model of the receiver's visible state.
  task automatic test_random();
    logic [31:0] w, exp_w;
    logic [3:0]  fl;
    bit          exp_rdy, exp_ovr, exp_par;
    exp_rdy = 0; exp_ovr = 0; exp_par = 0; exp_w = d0;
    for (int n = 0; n < 6; n++) begin
      w  = $urandom;
      fl = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        send_byte(0, w[i*8 +: 8], 1, fl[i], 1'b1);
        drive(0, 1'b1, $urandom_range(0, 3) * BIT);
      end
      if (exp_rdy) exp_ovr = 1;
      exp_rdy = 1; exp_w = w; exp_par = |fl;
      tests++; if (d0 !== exp_w) begin fails++; $display("FAIL rnd_data[%0d]: got %h want %h", n, d0, exp_w); end
      tests++; if ({rdy0, perr0, ovr0} !== {exp_rdy, exp_par, exp_ovr})
        begin fails++; $display("FAIL rnd_flags[%0d]: got %b want %b", n, {rdy0, perr0, ovr0}, {exp_rdy, exp_par, exp_ovr}); end
      if ($urandom_range(0, 1) == 1) begin
        ack();
        exp_rdy = 0; exp_ovr = 0; exp_par = 0;
        tests++; if ({rdy0, perr0, ovr0} !== 3'b000)
          begin fails++; $display("FAIL rnd_ack[%0d]: got %b want 000", n, {rdy0, perr0, ovr0}); end
      end
    end
    ack();
  endtask

  task automatic test_glitch_reset();
    int fe0 = fe_cnt;
    int t0  = to_cnt;
    drive(0, 1'b0, 3 * DIV);
    drive(0, 1'b1, 20 * BIT);
    tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL glitch_ready: got %b want 0", rdy0); end
    tests++; if (fe_cnt != fe0 || to_cnt != t0)
      begin fails++; $display("FAIL glitch_pulses: got %0d/%0d want 0/0", fe_cnt - fe0, to_cnt - t0); end
    send_byte(0, 8'h5A, 1, 0, 1'b1);
    drive(0, 1'b0, BIT);
    drive(0, 1'b1, 3 * BIT);
    @(negedge CLK) CLR = 1'b1;
    @(negedge CLK) CLR = 1'b0; rx0 = 1'b1;
    tests++; if ({d0, rdy0, perr0, ferr0, ovr0, terr0} !== 37'h0)
      begin fails++; $display("FAIL clr_outputs: got %h want 0", {d0, rdy0, perr0, ferr0, ovr0, terr0}); end
    drive(0, 1'b1, 25 * BIT);
    tests++; if (fe_cnt != fe0 || to_cnt != t0 || rdy0 !== 1'b0)
      begin fails++; $display("FAIL clr_after: got fe=%0d to=%0d rdy=%b want 0 0 0", fe_cnt - fe0, to_cnt - t0, rdy0); end
  endtask

  task automatic test_narrow();
    send_byte(1, 8'h34, 0, 0, 1'b1);
    send_byte(1, 8'h12, 0, 0, 1'b1);
    tests++; if (d1 !== 16'h1234) begin fails++; $display("FAIL narrow_data: got %h want 1234", d1); end
    tests++; if ({rdy1, perr1} !== 2'b10) begin fails++; $display("FAIL narrow_flags: got %b want 10", {rdy1, perr1}); end
  endtask

  initial begin
    test_reset();
    test_word_ok();
    test_parity();
    test_frame();
    test_timeout();
    test_overrun();
    test_random();
    test_glitch_reset();
    test_narrow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/usart_word_rx.md
Name: usart_word_rx

Overview:
Parametrised multi-byte USART receiver; successor to the fixed 32-bit receive path of the USART block. Assembles DATA_BYTES serial bytes (8N1 or 8E1/8O1) into one word, raises Data_Ready until acknowledged, and reports parity, framing, overrun and inter-byte timeout errors. Sits between the Rx pin and the BLDC command decoder.

Parameters:
DATA_BYTES, 4, bytes per word; Data_Rx width = 8*DATA_BYTES (1..8)
OVS_DIV, 27, CLK cycles per 16x oversample tick (50 MHz / (115200*16))
PARITY_EN, 1, 1 = parity bit after data bits; 0 = none
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0)
TIMEOUT_BITS, 20, max idle bit-times between bytes of one word before the partial word is discarded

Ports:
CLK  in  1  system clock, all logic on rising edge
CLR  in  1  reset: synchronous, active-high
Rx  in  1  serial input, idle high, asynchronous to CLK
CLR_Rec  in  1  read acknowledge; clears Data_Ready and the word error flags
Data_Rx  out  8*DATA_BYTES  received word; first byte received in bits [7:0]
Data_Ready  out  1  level; word valid, held until CLR_Rec
parity_err  out  1  level, valid with Data_Ready; 1 if any byte of the word failed parity
frame_err  out  1  one-CLK pulse; stop bit sampled low
overrun  out  1  sticky; word completed while Data_Ready=1; cleared by CLR_Rec
timeout_err  out  1  one-CLK pulse; partial word discarded on inter-byte timeout

Behaviour:
- Reset (CLR=1 at a CLK edge): all outputs 0, Data_Rx=0, FSM IDLE, byte index 0, divider and tick counters 0. Reset mid-frame abandons the frame with no error pulse.
- Rx passes through a 2-flop synchroniser; all decisions use the synchronised value.
- Tick generator asserts tick for 1 CLK every OVS_DIV cycles; it is free-running except that it restarts on the start-bit falling edge. Each bit = 16 ticks; sample point = tick 8 of the bit.
- FSM states:
  - IDLE: on synchronised falling edge go to START, oversample counter = 0.
  - START: at mid-bit, Rx=1 means false start, return to IDLE with no error; Rx=0 goes to DATA.
  - DATA: 8 samples, LSB first, one per 16 ticks; then go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: expected parity = XOR(data) ^ PARITY_ODD; a mismatch sets the internal word parity flag.
  - STOP: Rx=0 at mid-bit means frame_err pulse, byte and partial word discarded, byte index 0, back to IDLE. Rx=1 stores the byte at lane [byte_idx*8 +: 8] and byte_idx++.
- Word complete (byte_idx reaches DATA_BYTES) happens one CLK after the stop-bit sample of the last byte:
  - Data_Rx and parity_err load, Data_Ready=1, byte_idx=0.
  - If Data_Ready was already 1: overrun=1, and the new word overwrites Data_Rx and parity_err.
- The FSM returns to IDLE at the stop-bit mid-sample, so back-to-back frames are accepted.
- Timeout: while 0 < byte_idx < DATA_BYTES and the FSM is IDLE, count ticks. At TIMEOUT_BITS*16 ticks: timeout_err pulse, partial word and parity flag discarded, byte_idx=0. The count resets on each start edge.
- CLR_Rec at a CLK edge clears Data_Ready, parity_err and overrun. If word completion lands in the same cycle, completion wins: Data_Ready=1 with the new data, overrun=0.
- Data_Rx holds its last value after CLR_Rec.

Decomposition:
- Package usart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP), OVS=16, SAMPLE_PT=8, BITS_PER_BYTE=8.
- Sub-module usart_baud_tick (params OVS_DIV; ports CLK, CLR, restart, tick); shared later with the parametrised transmitter.

Test Plan:
- DATA_BYTES=4, even parity, send EF BE AD DE with correct parity -> Data_Ready=1, Data_Rx=32'hDEADBEEF, parity_err=0; CLR_Rec -> Data_Ready=0, Data_Rx unchanged.
- Same word with byte 0xAD sent with wrong parity bit -> Data_Rx=32'hDEADBEEF, parity_err=1; frame_err=0.
- Stop bit of 2nd byte driven low -> one frame_err pulse, no Data_Ready; then a clean 11 22 33 44 -> Data_Rx=32'h44332211.
- Send 2 bytes, idle 25 bit-times -> timeout_err pulse; then 4 clean bytes A1 B2 C3 D4 -> Data_Rx=32'hD4C3B2A1.
- Two full words with no CLR_Rec between them (01020304 then 05060708 on the wire) -> overrun=1, Data_Rx=32'h08070605; CLR_Rec clears overrun and Data_Ready.
- 3-tick low glitch on Rx, then CLR asserted mid-byte -> no Data_Ready, no error pulses, all outputs 0 after reset; PARITY_EN=0, DATA_BYTES=2 build receives 34 12 -> Data_Rx=16'h1234.
